// File: rtl/stopwatch_display.sv
// Display-side consumer of the stopwatch time bus: periodically samples the centisecond
// count, converts it to MM:SS.cc by repeated subtraction and drives six active-low digits.
module stopwatch_display #(
    parameter int unsigned REFRESH    = 32'd500000,
    parameter bit          BLANK_LEAD = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [18:0] time_in,
    input  logic        hold,
    output logic [6:0]  hex5,
    output logic [6:0]  hex4,
    output logic [6:0]  hex3,
    output logic [6:0]  hex2,
    output logic [6:0]  hex1,
    output logic [6:0]  hex0,
    output logic        upd,
    output logic        busy
);

    localparam logic [6:0] SegBlank = 7'b1111111;
    localparam logic [6:0] SegZero  = 7'b1000000;

    typedef enum logic [2:0] {
        StIdle,
        StWrap,
        StMin,
        StSec,
        StSplit,
        StDone
    } state_t;

    state_t          state_q, state_d;
    logic [31:0]     refresh_q;
    logic [18:0]     work_q, work_d;
    logic [6:0]      min_q, min_d;
    logic [6:0]      sec_q, sec_d;
    logic [6:0]      cs_q, cs_d;
    logic [5:0][3:0] dig_q, dig_d;
    logic [5:0][6:0] hex_q, hex_d;
    logic            upd_q, upd_d;
    logic            tick;
    logic [7:0]      min_bcd, sec_bcd, cs_bcd;

    // Tens and ones of a value in 0..99, packed as {tens, ones}.
    function automatic logic [7:0] split_bcd(input logic [6:0] v);
        logic [3:0] t;
        t = 4'd0;
        for (int i = 1; i < 10; i++) begin
            if (v >= 7'(i * 10)) t = 4'(i);
        end
        return {t, 4'(v - 7'(t * 10))};
    endfunction

    function automatic logic [6:0] seg(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SegBlank;
        endcase
        return s;
    endfunction

    assign tick    = (refresh_q == REFRESH - 1);
    assign min_bcd = split_bcd(min_q);
    assign sec_bcd = split_bcd(sec_q);
    assign cs_bcd  = split_bcd(cs_q);

    // Refresh counter free-runs independently of the conversion state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            refresh_q <= 32'd0;
        end else if (tick) begin
            refresh_q <= 32'd0;
        end else begin
            refresh_q <= refresh_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            work_q   <= 19'd0;
            min_q    <= 7'd0;
            sec_q    <= 7'd0;
            cs_q     <= 7'd0;
            dig_q    <= '0;
            hex_q[5] <= BLANK_LEAD ? SegBlank : SegZero;
            hex_q[4] <= SegZero;
            hex_q[3] <= SegZero;
            hex_q[2] <= SegZero;
            hex_q[1] <= SegZero;
            hex_q[0] <= SegZero;
            upd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            min_q   <= min_d;
            sec_q   <= sec_d;
            cs_q    <= cs_d;
            dig_q   <= dig_d;
            hex_q   <= hex_d;
            upd_q   <= upd_d;
        end
    end

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        min_d   = min_q;
        sec_d   = sec_q;
        cs_d    = cs_q;
        dig_d   = dig_q;
        hex_d   = hex_q;
        upd_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (tick && !hold) begin
                    work_d  = time_in;
                    state_d = StWrap;
                end
            end
            StWrap: begin
                // One hour never fits twice into a 19-bit count, so one subtraction suffices.
                if (work_q >= 19'd360000) work_d = work_q - 19'd360000;
                min_d   = 7'd0;
                state_d = StMin;
            end
            StMin: begin
                if (work_q >= 19'd6000) begin
                    work_d = work_q - 19'd6000;
                    min_d  = min_q + 7'd1;
                end else begin
                    sec_d   = 7'd0;
                    state_d = StSec;
                end
            end
            StSec: begin
                if (work_q >= 19'd100) begin
                    work_d = work_q - 19'd100;
                    sec_d  = sec_q + 7'd1;
                end else begin
                    cs_d    = work_q[6:0];
                    state_d = StSplit;
                end
            end
            StSplit: begin
                dig_d   = {min_bcd, sec_bcd, cs_bcd};
                state_d = StDone;
            end
            StDone: begin
                hex_d[5] = (BLANK_LEAD && dig_q[5] == 4'd0) ? SegBlank : seg(dig_q[5]);
                hex_d[4] = seg(dig_q[4]);
                hex_d[3] = seg(dig_q[3]);
                hex_d[2] = seg(dig_q[2]);
                hex_d[1] = seg(dig_q[1]);
                hex_d[0] = seg(dig_q[0]);
                upd_d    = 1'b1;
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign hex5 = hex_q[5];
    assign hex4 = hex_q[4];
    assign hex3 = hex_q[3];
    assign hex2 = hex_q[2];
    assign hex1 = hex_q[1];
    assign hex0 = hex_q[0];
    assign upd  = upd_q;
    assign busy = (state_q != StIdle);

endmodule
